// File: rtl/gps_sig_gen.sv
// gps_sig_gen: synthetic GPS L1 C/A 1-bit I/Q sample source.
// Produces the C/A code of one PRN, starting at a programmed code phase.
// The code is mixed with a quadrature square-wave Doppler LO, and one
// I/Q sample is emitted per adc_clk period.
// Ports:
//   clk, rst (async, active-low)
//   start   - 1-cycle pulse; latches prn/code_phase/doppler_omega/sample_count when idle
//   stop    - abort to IDLE next cycle; outputs forced low, no done
//   prn, code_phase, doppler_omega, sample_count - run configuration
//   data_bit - nav bit XORed onto I and Q, sampled live at each sample update
//   adc_clk  - 50% duty sample strobe (CLK_DIV clk cycles per period)
//   i_sample, q_sample - 1-bit samples, updated at the start of each low half
//   busy     - high outside IDLE
//   done     - 1-cycle pulse after the final sample period
module gps_sig_gen #(
  parameter int unsigned CLK_DIV        = 20,
  parameter int unsigned CODE_NCO_OMEGA = 67027
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [5:0]  prn,
  input  logic [9:0]  code_phase,
  input  logic [15:0] doppler_omega,
  input  logic [15:0] sample_count,
  input  logic        data_bit,
  output logic        adc_clk,
  output logic        i_sample,
  output logic        q_sample,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_RUN, S_DONE} state_t;

  state_t         r_state;
  logic [10:1]    r_g1;
  logic [10:1]    r_g2;
  logic [3:0]     r_t1;
  logic [3:0]     r_t2;
  logic [9:0]     r_seek_cnt;
  logic [15:0]    r_remaining;
  logic [15:0]    r_omega;
  logic [15:0]    r_dph;
  logic [17:0]    r_cph;
  logic [DW-1:0]  r_div_cnt;

  logic [3:0]     w_t1;
  logic [3:0]     w_t2;
  logic           w_prn_ok;
  logic [10:1]    w_g1_next;
  logic [10:1]    w_g2_next;
  logic           w_chip;
  logic           w_lo_i;
  logic           w_lo_q;
  logic [18:0]    w_cph_sum;

  // G2 output tap pairs per PRN
  always_comb begin
    w_t1 = 4'd1;
    w_t2 = 4'd1;
    case (prn)
      6'd1:  begin w_t1 = 4'd2; w_t2 = 4'd6;  end
      6'd2:  begin w_t1 = 4'd3; w_t2 = 4'd7;  end
      6'd3:  begin w_t1 = 4'd4; w_t2 = 4'd8;  end
      6'd4:  begin w_t1 = 4'd5; w_t2 = 4'd9;  end
      6'd5:  begin w_t1 = 4'd1; w_t2 = 4'd9;  end
      6'd6:  begin w_t1 = 4'd2; w_t2 = 4'd10; end
      6'd7:  begin w_t1 = 4'd1; w_t2 = 4'd8;  end
      6'd8:  begin w_t1 = 4'd2; w_t2 = 4'd9;  end
      6'd9:  begin w_t1 = 4'd3; w_t2 = 4'd10; end
      6'd10: begin w_t1 = 4'd2; w_t2 = 4'd3;  end
      6'd11: begin w_t1 = 4'd3; w_t2 = 4'd4;  end
      6'd12: begin w_t1 = 4'd5; w_t2 = 4'd6;  end
      6'd13: begin w_t1 = 4'd6; w_t2 = 4'd7;  end
      6'd14: begin w_t1 = 4'd7; w_t2 = 4'd8;  end
      6'd15: begin w_t1 = 4'd8; w_t2 = 4'd9;  end
      6'd16: begin w_t1 = 4'd9; w_t2 = 4'd10; end
      6'd17: begin w_t1 = 4'd1; w_t2 = 4'd4;  end
      6'd18: begin w_t1 = 4'd2; w_t2 = 4'd5;  end
      6'd19: begin w_t1 = 4'd3; w_t2 = 4'd6;  end
      6'd20: begin w_t1 = 4'd4; w_t2 = 4'd7;  end
      6'd21: begin w_t1 = 4'd5; w_t2 = 4'd8;  end
      6'd22: begin w_t1 = 4'd6; w_t2 = 4'd9;  end
      6'd23: begin w_t1 = 4'd1; w_t2 = 4'd3;  end
      6'd24: begin w_t1 = 4'd4; w_t2 = 4'd6;  end
      6'd25: begin w_t1 = 4'd5; w_t2 = 4'd7;  end
      6'd26: begin w_t1 = 4'd6; w_t2 = 4'd8;  end
      6'd27: begin w_t1 = 4'd7; w_t2 = 4'd9;  end
      6'd28: begin w_t1 = 4'd8; w_t2 = 4'd10; end
      6'd29: begin w_t1 = 4'd1; w_t2 = 4'd6;  end
      6'd30: begin w_t1 = 4'd2; w_t2 = 4'd7;  end
      6'd31: begin w_t1 = 4'd3; w_t2 = 4'd8;  end
      6'd32: begin w_t1 = 4'd4; w_t2 = 4'd9;  end
      default: begin w_t1 = 4'd1; w_t2 = 4'd1; end
    endcase
  end

  assign w_prn_ok  = (prn != 6'd0) && (prn <= 6'd32);
  assign w_g1_next = {r_g1[9:1], r_g1[3] ^ r_g1[10]};
  assign w_g2_next = {r_g2[9:1], r_g2[2] ^ r_g2[3] ^ r_g2[6] ^ r_g2[8] ^ r_g2[9] ^ r_g2[10]};
  assign w_chip    = r_g1[10] ^ r_g2[r_t1] ^ r_g2[r_t2];
  // Quadrant q = dph[15:14]: I is low for q=0,1; Q is high for q=1,2
  assign w_lo_i    = r_dph[15];
  assign w_lo_q    = r_dph[15] ^ r_dph[14];
  assign w_cph_sum = {1'b0, r_cph} + 19'(CODE_NCO_OMEGA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_g1        <= '1;
      r_g2        <= '1;
      r_t1        <= 4'd1;
      r_t2        <= 4'd1;
      r_seek_cnt  <= '0;
      r_remaining <= '0;
      r_omega     <= '0;
      r_dph       <= '0;
      r_cph       <= '0;
      r_div_cnt   <= '0;
      adc_clk     <= 1'b0;
      i_sample    <= 1'b0;
      q_sample    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (stop) begin
      r_state  <= S_IDLE;
      adc_clk  <= 1'b0;
      i_sample <= 1'b0;
      q_sample <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done    <= 1'b0;
          adc_clk <= 1'b0;
          if (start && w_prn_ok) begin
            r_state     <= S_SEEK;
            busy        <= 1'b1;
            r_g1        <= '1;
            r_g2        <= '1;
            r_t1        <= w_t1;
            r_t2        <= w_t2;
            r_seek_cnt  <= code_phase;
            r_remaining <= sample_count;
            r_omega     <= doppler_omega;
            r_dph       <= '0;
            r_cph       <= '0;
            r_div_cnt   <= '0;
          end
        end
        S_SEEK: begin
          if (r_seek_cnt != 10'd0) begin
            r_g1       <= w_g1_next;
            r_g2       <= w_g2_next;
            r_seek_cnt <= r_seek_cnt - 10'd1;
          end
          // Zero phase still spends one cycle here
          if (r_seek_cnt <= 10'd1) begin
            if (r_remaining == 16'd0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state   <= S_RUN;
              r_div_cnt <= '0;
            end
          end
        end
        S_RUN: begin
          adc_clk   <= (r_div_cnt >= DIV_HALF);
          r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
          // The period boundary after the last sample's high half is where RUN ends
          if (r_div_cnt == '0) begin
            if (r_remaining == 16'd0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              adc_clk <= 1'b0;
            end else begin
              i_sample    <= w_chip ^ w_lo_i ^ data_bit;
              q_sample    <= w_chip ^ w_lo_q ^ data_bit;
              r_dph       <= r_dph + r_omega;
              r_cph       <= w_cph_sum[17:0];
              r_remaining <= r_remaining - 16'd1;
              if (w_cph_sum[18]) begin
                r_g1 <= w_g1_next;
                r_g2 <= w_g2_next;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_sig_gen.sv
// Directed bench for gps_sig_gen. Two instances share stimulus: A steps
// one chip every 4 samples (CODE_NCO_OMEGA=65536), B never steps the code.
// Expected I/Q pairs are queued when a run is started and popped on each
// adc_clk rising edge.
module tb_gps_sig_gen;

  logic        clk = 1'b0;
  logic        rst, start, stop, data_bit;
  logic [5:0]  prn;
  logic [9:0]  code_phase;
  logic [15:0] doppler_omega, sample_count;
  logic        a_adc, a_i, a_q, a_busy, a_done;
  logic        b_adc, b_i, b_q, b_busy, b_done;

  always #5 clk = ~clk;

  gps_sig_gen #(.CLK_DIV(20), .CODE_NCO_OMEGA(65536)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .prn(prn),
    .code_phase(code_phase), .doppler_omega(doppler_omega),
    .sample_count(sample_count), .data_bit(data_bit),
    .adc_clk(a_adc), .i_sample(a_i), .q_sample(a_q), .busy(a_busy), .done(a_done));

  gps_sig_gen #(.CLK_DIV(20), .CODE_NCO_OMEGA(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .prn(prn),
    .code_phase(code_phase), .doppler_omega(doppler_omega),
    .sample_count(sample_count), .data_bit(data_bit),
    .adc_clk(b_adc), .i_sample(b_i), .q_sample(b_q), .busy(b_busy), .done(b_done));

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];
  // First ten chips of PRN1 (octal 1440) and PRN2 (octal 1620), first chip at MSB
  logic [9:0] c_prn1 = 10'b1100100000;
  logic [9:0] c_prn2 = 10'b1110010000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] model(input logic [9:0] chips, input int unsigned k,
                                       input int unsigned s, input logic [15:0] om, input logic db);
    logic [15:0] ph;
    int unsigned quad;
    logic lo_i, lo_q, c;
    ph   = 16'(s * om);
    quad = ph / 16384;
    lo_i = (quad >= 2);
    lo_q = (quad == 1) || (quad == 2);
    c    = chips[9 - k];
    return {c ^ lo_i ^ db, c ^ lo_q ^ db};
  endfunction

  // ---------------- monitors ----------------
  int cyc = 0;
  logic pa_adc = 1'b0, pa_i = 1'b0, pa_q = 1'b0, pa_busy = 1'b0, pa_done = 1'b0;
  logic pb_adc = 1'b0;
  int edges_a = 0, edges_b = 0, done_a = 0, done_b = 0;
  int lowcnt = 0, highcnt = 0, t_busy = 0, lat_a = -1;
  bit had_fall = 1'b0, first_pend = 1'b0;

  always @(negedge clk) begin
    logic [1:0] e;
    cyc++;
    if (a_busy && !pa_busy) begin
      t_busy     = cyc;
      first_pend = 1'b1;
      had_fall   = 1'b0;
    end
    if (a_adc && !pa_adc) begin
      edges_a++;
      if (first_pend) begin
        lat_a      = cyc - t_busy;
        first_pend = 1'b0;
      end else if (had_fall) begin
        chk("a_low_len", 32'(lowcnt), 32'd10);
      end
      chk("a_exp_avail", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) begin
        e = exp_a.pop_front();
        chk("a_iq", 32'({a_i, a_q}), 32'(e));
      end
      highcnt = 1;
    end else if (a_adc) begin
      highcnt++;
    end
    if (!a_adc && pa_adc) begin
      if (a_busy) chk("a_high_len", 32'(highcnt), 32'd10);
      lowcnt   = 1;
      had_fall = 1'b1;
    end else if (!a_adc) begin
      lowcnt++;
    end
    if (a_busy && ({a_i, a_q} != {pa_i, pa_q}))
      chk("a_iq_change_at_low_start", 32'(!a_adc && (lowcnt == 1 || !had_fall)), 32'd1);
    if (a_done) done_a++;
    if (pa_done) chk("a_busy_after_done", 32'(a_busy), 32'd0);
    pa_adc = a_adc; pa_i = a_i; pa_q = a_q; pa_busy = a_busy; pa_done = a_done;
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (b_adc && !pb_adc) begin
      edges_b++;
      chk("b_exp_avail", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) begin
        e = exp_b.pop_front();
        chk("b_iq", 32'({b_i, b_q}), 32'(e));
      end
    end
    if (b_done) done_b++;
    pb_adc = b_adc;
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_cfg(input logic [5:0] p, input logic [9:0] cp, input logic [15:0] om,
                         input logic [15:0] n, input logic db);
    logic [9:0] tbl;
    tbl = (p == 6'd1) ? c_prn1 : c_prn2;
    edges_a = 0; edges_b = 0; done_a = 0; done_b = 0; lat_a = -1;
    for (int unsigned s = 0; s < 32'(n); s++) begin
      exp_a.push_back(model(tbl, 32'(cp) + s / 4, s, om, db));
      exp_b.push_back(model(tbl, 32'(cp), s, om, db));
    end
    @(negedge clk);
    prn = p; code_phase = cp; doppler_omega = om; sample_count = n; data_bit = db;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Config is latched; these changes must not leak into the run
    prn = 6'd7; code_phase = 10'd99; doppler_omega = 16'h1357; sample_count = 16'd3;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!a_busy && !b_busy) break;
      @(negedge clk);
    end
    chk("idle_in_budget", 32'(a_busy | b_busy), 32'd0);
  endtask

  task automatic full_run(input string tag, input logic [5:0] p, input logic [9:0] cp,
                          input logic [15:0] om, input logic [15:0] n, input logic db);
    run_cfg(p, cp, om, n, db);
    wait_idle(2000);
    chk({tag, "_edges_a"}, 32'(edges_a), 32'(n));
    chk({tag, "_edges_b"}, 32'(edges_b), 32'(n));
    chk({tag, "_queue_empty"}, 32'(exp_a.size() + exp_b.size()), 32'd0);
    chk({tag, "_done_a"}, 32'(done_a), 32'd1);
    chk({tag, "_done_b"}, 32'(done_b), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; data_bit = 1'b0;
    prn = 6'd1; code_phase = '0; doppler_omega = '0; sample_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_adc", 32'(a_adc), 32'd0);
    chk("rst_i", 32'(a_i), 32'd0);
    chk("rst_q", 32'(a_q), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // PRN1, phase 0, no Doppler, 40 samples; first edge 1 SEEK + 11 cycles after busy
    full_run("t1", 6'd1, 10'd0, 16'd0, 16'd40, 1'b0);
    chk("t1_latency", 32'(lat_a), 32'd12);

    // PRN1, phase 2: two SEEK cycles, stream starts at third chip
    full_run("t2", 6'd1, 10'd2, 16'd0, 16'd32, 1'b0);
    chk("t2_latency", 32'(lat_a), 32'd13);

    // Quarter-cycle Doppler steps
    full_run("t3", 6'd1, 10'd0, 16'd16384, 16'd8, 1'b0);

    // PRN2 with nav bit set inverts both channels
    full_run("t_prn2", 6'd2, 10'd0, 16'd0, 16'd40, 1'b1);

    // Edge counts at the boundaries
    full_run("t4_n1", 6'd1, 10'd0, 16'd0, 16'd1, 1'b0);
    full_run("t4_n7", 6'd1, 10'd0, 16'd16384, 16'd7, 1'b1);
    full_run("t4_n0", 6'd1, 10'd3, 16'd0, 16'd0, 1'b0);

    // Invalid PRN starts are ignored
    @(negedge clk); prn = 6'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_prn0_busy", 32'(a_busy | b_busy), 32'd0);
    @(negedge clk); prn = 6'd33; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_prn33_busy", 32'(a_busy | b_busy), 32'd0);

    // Start during RUN is ignored; the queued stream must come out untouched
    run_cfg(6'd1, 10'd0, 16'd16384, 16'd12, 1'b0);
    repeat (100) @(negedge clk);
    prn = 6'd2; code_phase = 10'd5; doppler_omega = 16'h8000; sample_count = 16'd2;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle(2000);
    chk("t5_busy_start_edges", 32'(edges_a), 32'd12);
    chk("t5_busy_start_queue", 32'(exp_a.size() + exp_b.size()), 32'd0);
    chk("t5_busy_start_done", 32'(done_a), 32'd1);

    // Stop in the high half of a period
    run_cfg(6'd1, 10'd0, 16'd0, 16'd20, 1'b1);
    for (int k = 0; k < 500 && edges_a < 5; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("t6_stop_adc", 32'(a_adc), 32'd0);
    chk("t6_stop_i", 32'(a_i), 32'd0);
    chk("t6_stop_q", 32'(a_q), 32'd0);
    chk("t6_stop_busy", 32'(a_busy | b_busy), 32'd0);
    repeat (30) @(negedge clk);
    chk("t6_stop_no_done", 32'(done_a + done_b), 32'd0);
    exp_a.delete(); exp_b.delete();

    // Asynchronous reset in the middle of a long SEEK
    run_cfg(6'd1, 10'd500, 16'd0, 16'd8, 1'b0);
    repeat (10) @(negedge clk);
    chk("t6_seek_busy_before", 32'(a_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(a_busy | b_busy), 32'd0);
    chk("t6_rst_adc", 32'(a_adc | b_adc), 32'd0);
    chk("t6_rst_iq", 32'({a_i, a_q}), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("t6_rst_no_done", 32'(done_a + done_b), 32'd0);
    exp_a.delete(); exp_b.delete();

    // Restart after abort
    full_run("t6_restart", 6'd1, 10'd0, 16'd16384, 16'd8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
